// File: rtl/mux_4to1_6bit_reg.sv
// mux_4to1_6bit_reg
//   Registered 4-to-1 multiplexer for the 6-bit CPU datapath. One of four
//   buses is selected by a 2-bit code and captured into an output register
//   on a rising clock edge when the capture enable is high. A sticky valid
//   flag and the captured select code travel alongside the data.
//
//   Optional build feature, controlled by the macro MUX_PARITY_EN:
//     defined   -> adds out_par, the registered even parity (^) of out.
//     undefined -> out_par and its register do not exist.
//
//   Handshake: en is a one-sided capture strobe with no back-pressure. Every
//   rising clk edge that sees en=1 (and rst_n=1) loads out/sel_q and sets
//   out_valid. An edge with en=0 leaves all outputs unchanged. out_valid is
//   sticky: it stays high from the first capture until the next reset.
//   Results appear exactly one cycle after sel/data are sampled, and there
//   is no combinational path from any input to any output.
module mux_4to1_6bit_reg #(
  parameter int               WIDTH     = 6,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [1:0]       sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
`ifdef MUX_PARITY_EN
  output logic             out_par,
`endif
  output logic [1:0]       sel_q
);

  // Input buses gathered into an array so that selection is a plain index.
  // An index of X reads back as X in simulation, so an unknown select is
  // never masked by a priority chain or a default branch.
  logic [WIDTH-1:0] w_bus [4];
  logic [WIDTH-1:0] w_sel_word;

  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic [1:0]       r_sel_q;

  assign w_bus[0] = i0;
  assign w_bus[1] = i1;
  assign w_bus[2] = i2;
  assign w_bus[3] = i3;

  // Select the addressed bus; all four codes are legal.
  always_comb begin
    w_sel_word = w_bus[sel];
  end

  // Capture register for data, select code and sticky valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= RESET_VAL;
      r_out_valid <= 1'b0;
      r_sel_q     <= 2'b00;
    end else if (en) begin
      r_out       <= w_sel_word;
      r_out_valid <= 1'b1;
      r_sel_q     <= sel;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign sel_q     = r_sel_q;

`ifdef MUX_PARITY_EN
  logic w_sel_par;
  logic r_out_par;

  // Parity is computed from the word being captured so it lines up with out.
  always_comb begin
    w_sel_par = ^w_sel_word;
  end

  // Parity register, loaded under exactly the same conditions as r_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_par <= ^RESET_VAL;
    end else if (en) begin
      r_out_par <= w_sel_par;
    end
  end

  assign out_par = r_out_par;
`endif

endmodule

// File: tb/tb_mux_4to1_6bit_reg.sv
// Testbench for mux_4to1_6bit_reg. Expected outputs come from a small
// reference model ({m_par, m_valid, m_sel, m_out}) that is updated when
// stimulus is driven. The packed expectation is pushed to exp_q, then
// popped and compared after the following rising edge.
module tb_mux_4to1_6bit_reg;

  localparam int W  = 6;
  localparam int EW = 1 + 1 + 2 + W;  // {par, valid, sel_q, out}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;  // 20 ns period

  logic         rst_n;
  logic [W-1:0] i0, i1, i2, i3;
  logic [1:0]   sel;
  logic         en;
  logic [W-1:0] out;
  logic         out_valid;
  logic [1:0]   sel_q;
  logic         w_par;

  mux_4to1_6bit_reg #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i0        (i0),
    .i1        (i1),
    .i2        (i2),
    .i3        (i3),
    .sel       (sel),
    .en        (en),
    .out       (out),
    .out_valid (out_valid),
`ifdef MUX_PARITY_EN
    .out_par   (w_par),
`endif
    .sel_q     (sel_q)
  );

`ifndef MUX_PARITY_EN
  assign w_par = 1'b0;
`endif

  // ---------------- model / scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]  m_out;
  logic          m_valid;
  logic [1:0]    m_sel;
  logic [EW-1:0] exp_q [$];

  function automatic logic [EW-1:0] model_vec();
    logic p;
`ifdef MUX_PARITY_EN
    p = ^m_out;
`else
    p = 1'b0;
`endif
    return {p, m_valid, m_sel, m_out};
  endfunction

  task automatic model_reset();
    m_out   = '0;
    m_valid = 1'b0;
    m_sel   = 2'b00;
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of stimulus at the falling edge. t_sel is 3 bits wide
  // to model a wider source; only its low two bits reach the port.
  task automatic drive(input logic t_en, input logic [2:0] t_sel,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
    logic [W-1:0] arr [4];
    @(negedge clk);
    en  = t_en;
    sel = t_sel[1:0];
    i0 = a; i1 = b; i2 = c; i3 = d;
    if (t_en && rst_n) begin
      arr[0] = a; arr[1] = b; arr[2] = c; arr[3] = d;
      m_out   = arr[t_sel % 4];
      m_sel   = 2'(t_sel % 4);
      m_valid = 1'b1;
    end
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [EW-1:0] obs;
    rst_n = 1'b0;
    en = 1'b1; sel = 2'd3;
    i0 = 6'h11; i1 = 6'h22; i2 = 6'h33; i3 = 6'h3F;
    model_reset();
    #3;  // before any clock edge
    obs = {w_par, out_valid, sel_q, out};
    n_checks++;
    if (obs !== model_vec()) begin
      n_fail++;
      $display("FAIL reset_no_clock: got %b, expected %b", obs, model_vec());
    end
    repeat (2) @(posedge clk);
    #1;
    obs = {w_par, out_valid, sel_q, out};
    n_checks++;
    if (obs !== model_vec()) begin
      n_fail++;
      $display("FAIL reset_held_with_en: got %b, expected %b", obs, model_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sel_step();
    logic [EW-1:0] obs, e;
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 3'(s), 6'd0, 6'd1, 6'd2, 6'd3);
      obs = {w_par, out_valid, sel_q, out};
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sel_step_%0d: scoreboard empty, got %b", s, obs);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL sel_step_%0d: got %b, expected %b", s, obs, e);
        end
      end
    end
  endtask

  task automatic test_sel_wrap();
    logic [EW-1:0] obs, e;
    for (int s = 4; s < 8; s++) begin
      drive(1'b1, 3'(s), 6'd0, 6'd1, 6'd2, 6'd3);
      obs = {w_par, out_valid, sel_q, out};
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sel_wrap_%0d: scoreboard empty, got %b", s, obs);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL sel_wrap_%0d: got %b, expected %b", s, obs, e);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [EW-1:0] obs, e;
    drive(1'b1, 3'd2, 6'h01, 6'h02, 6'h2A, 6'h04);
    for (int k = 0; k < 4; k++) begin
      if (k > 0)
        drive(1'b0, 3'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
              6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
              6'($urandom_range(0, 63)));
      obs = {w_par, out_valid, sel_q, out};
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL hold_%0d: scoreboard empty, got %b", k, obs);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL hold_%0d: got %b, expected %b", k, obs, e);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [EW-1:0] obs, e;
    drive(1'b1, 3'd3, 6'h00, 6'h00, 6'h00, 6'h3F);
    e = exp_q.pop_front();
    obs = {w_par, out_valid, sel_q, out};
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL mid_reset_pre: got %b, expected %b", obs, e);
    end
    #4;  // mid-cycle, away from both edges
    rst_n = 1'b0;
    model_reset();
    #2;
    obs = {w_par, out_valid, sel_q, out};
    n_checks++;
    if (obs !== model_vec()) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %b, expected %b", obs, model_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 3'd1, 6'h05, 6'h15, 6'h25, 6'h35);
    obs = {w_par, out_valid, sel_q, out};
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL mid_reset_recapture: got %b, expected %b", obs, e);
    end
  endtask

  task automatic test_parity();
    logic [EW-1:0] obs, e;
    drive(1'b1, 3'd0, 6'b000111, 6'h00, 6'h00, 6'h00);
    obs = {w_par, out_valid, sel_q, out};
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL parity_odd_word: got %b, expected %b", obs, e);
    end
    drive(1'b1, 3'd2, 6'h00, 6'h00, 6'b000011, 6'h00);
    obs = {w_par, out_valid, sel_q, out};
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL parity_even_word: got %b, expected %b", obs, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] obs, e;
    for (int k = 0; k < 24; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
            6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
      obs = {w_par, out_valid, sel_q, out};
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b2b_%0d: scoreboard empty, got %b", k, obs);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL b2b_%0d: got %b, expected %b", k, obs, e);
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_sel_step();
    test_sel_wrap();
    test_hold();
    test_mid_reset();
    test_parity();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
